// File: rtl/tag_sort_pkg.sv
// rtl/tag_sort_pkg.sv - shared constants and encodings for the tag sorter control path
package tag_sort_pkg;

    localparam int TAG_W      = 12;
    localparam int NUM_STAGES = 3;

    localparam logic OP_INS = 1'b0;
    localparam logic OP_DEL = 1'b1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/tag_sort_vld_pipe.sv
// rtl/tag_sort_vld_pipe.sv - per-stage valid/op shift register with downstream hold
module tag_sort_vld_pipe #(
    parameter int NUM_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  issue,
    input  logic                  issue_op,
    output logic [NUM_STAGES-1:0] stage_vld,
    output logic [NUM_STAGES-1:0] stage_op,
    output logic [NUM_STAGES-1:1] stage_ena_hi
);

    // Advance valid/op one stage per unfrozen cycle; op is forced low on empty stages
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            stage_op  <= '0;
        end else if (!hold) begin
            stage_vld <= {stage_vld[NUM_STAGES-2:0], issue};
            stage_op  <= {stage_op[NUM_STAGES-2:0] & stage_vld[NUM_STAGES-2:0],
                          issue & issue_op};
        end
    end

    assign stage_ena_hi = {(NUM_STAGES-1){~hold}} & stage_vld[NUM_STAGES-2:0];

endmodule

// File: rtl/tag_sort_pipe_ctrl.sv
// rtl/tag_sort_pipe_ctrl.sv - insert/delete-min arbiter, drain FSM and occupancy counter
module tag_sort_pipe_ctrl
    import tag_sort_pkg::*;
#(
    parameter int TAG_W      = tag_sort_pkg::TAG_W,
    parameter int NUM_STAGES = tag_sort_pkg::NUM_STAGES,
    parameter int CAP        = 64,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  ins_valid,
    input  logic [TAG_W-1:0]      ins_tag,
    output logic                  ins_ready,
    input  logic                  del_req,
    output logic                  del_ack,
    output logic [TAG_W-1:0]      del_tag,
    input  logic [TAG_W-1:0]      min_tag_in,
    output logic [TAG_W-1:0]      issue_tag,
    output logic [NUM_STAGES-1:0] stage_ena,
    output logic [NUM_STAGES-1:0] stage_vld,
    output logic [NUM_STAGES-1:0] stage_op,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);

    state_t                state;
    state_t                state_nxt;
    logic                  pri_del;
    logic                  issue_ins;
    logic                  issue_del;
    logic                  issue;
    logic                  pipe_empty;
    logic                  del_elig;
    logic [NUM_STAGES-1:1] stage_ena_hi;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(CAP));
    assign pipe_empty = ~|stage_vld;
    assign del_elig   = del_req & ~empty;
    assign issue      = issue_ins | issue_del;
    assign issue_tag  = issue_del ? min_tag_in : ins_tag;
    assign stage_ena  = {stage_ena_hi, issue};

    // Arbitration and next-state: a delete never enters behind live ops, it drains first
    always_comb begin
        state_nxt = state;
        issue_ins = 1'b0;
        issue_del = 1'b0;
        ins_ready = 1'b0;
        case (state)
            ST_RUN: begin
                ins_ready = ~hold & ~full & ~(del_elig & pri_del);
                if (ins_valid && ins_ready) begin
                    issue_ins = 1'b1;
                end else if (!hold && del_elig) begin
                    if (pipe_empty) begin
                        issue_del = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty && !hold) begin
                    issue_del = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Fairness bit flips on every issue; occupancy moves by one per issue
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_del <= 1'b0;
            count   <= '0;
        end else begin
            if (issue) begin
                pri_del <= ~pri_del;
            end
            if (issue_ins) begin
                count <= count + CNT_W'(1);
            end else if (issue_del) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Delete completion is reported the cycle after issue, independent of hold
    always_ff @(posedge clk) begin
        if (rst) begin
            del_ack <= 1'b0;
            del_tag <= '0;
        end else begin
            del_ack <= issue_del;
            if (issue_del) begin
                del_tag <= min_tag_in;
            end
        end
    end

    tag_sort_vld_pipe #(
        .NUM_STAGES(NUM_STAGES)
    ) u_vld_pipe (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .issue       (issue),
        .issue_op    (issue_del ? OP_DEL : OP_INS),
        .stage_vld   (stage_vld),
        .stage_op    (stage_op),
        .stage_ena_hi(stage_ena_hi)
    );

endmodule

// File: tb/tb_tag_sort_pipe_ctrl.sv
// tb/tb_tag_sort_pipe_ctrl.sv - self-checking bench for tag_sort_pipe_ctrl
module tb_tag_sort_pipe_ctrl;

    localparam int TAG_W = 12;
    localparam int NS    = 3;
    localparam int CAP   = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hold = 1'b0;
    logic             ins_valid = 1'b0;
    logic [TAG_W-1:0] ins_tag = '0;
    logic             ins_ready;
    logic             del_req = 1'b0;
    logic             del_ack;
    logic [TAG_W-1:0] del_tag;
    logic [TAG_W-1:0] min_tag_in = '0;
    logic [TAG_W-1:0] issue_tag;
    logic [NS-1:0]    stage_ena;
    logic [NS-1:0]    stage_vld;
    logic [NS-1:0]    stage_op;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    tag_sort_pipe_ctrl #(
        .TAG_W(TAG_W), .NUM_STAGES(NS), .CAP(CAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .ins_valid(ins_valid), .ins_tag(ins_tag), .ins_ready(ins_ready),
        .del_req(del_req), .del_ack(del_ack), .del_tag(del_tag),
        .min_tag_in(min_tag_in), .issue_tag(issue_tag),
        .stage_ena(stage_ena), .stage_vld(stage_vld), .stage_op(stage_op),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: pipeline as a list of slot contents (-1 empty, 0 insert, 1 delete)
    int   m_pipe [NS];
    int   m_count;
    bit   m_drain;
    bit   m_pri_del;
    bit   m_ack;
    int   m_tag;
    bit   model_on = 0;

    function automatic bit m_pipe_empty();
        for (int i = 0; i < NS; i++) if (m_pipe[i] >= 0) return 0;
        return 1;
    endfunction

    // {ready, issue insert, issue delete, start drain}
    function automatic logic [3:0] decide();
        bit rdy = 0, ii = 0, id = 0, gd = 0;
        bit ins_ok, del_ok;
        if (!hold) begin
            if (m_drain) begin
                if (m_pipe_empty()) id = 1;
            end else begin
                ins_ok = ins_valid && (m_count < CAP);
                del_ok = del_req && (m_count > 0);
                rdy = (m_count < CAP) && !(del_ok && m_pri_del);
                if (ins_ok && (!del_ok || !m_pri_del)) ii = 1;
                else if (del_ok) begin
                    if (m_pipe_empty()) id = 1;
                    else gd = 1;
                end
            end
        end
        return {rdy, ii, id, gd};
    endfunction

    // Model advance at each active edge
    always @(posedge clk) begin
        logic [3:0] d;
        if (rst) begin
            for (int i = 0; i < NS; i++) m_pipe[i] = -1;
            m_count = 0; m_drain = 0; m_pri_del = 0; m_ack = 0; m_tag = 0;
            model_on = 1;
        end else if (model_on) begin
            d = decide();
            m_ack = d[1];
            if (d[1]) m_tag = int'(min_tag_in);
            if (!hold) begin
                for (int i = NS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = d[2] ? 0 : (d[1] ? 1 : -1);
            end
            if (d[2]) m_count++;
            if (d[1]) m_count--;
            if (d[2] || d[1]) m_pri_del = !m_pri_del;
            if (d[1]) m_drain = 0;
            if (d[0]) m_drain = 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [3:0] d;
        if (model_on) begin
            d = decide();
            chk("ins_ready", int'(ins_ready), int'(d[3]));
            chk("stage_ena0", int'(stage_ena[0]), int'(d[2] | d[1]));
            if (d[2]) chk("issue_tag_ins", int'(issue_tag), int'(ins_tag));
            if (d[1]) chk("issue_tag_del", int'(issue_tag), int'(min_tag_in));
            for (int i = 1; i < NS; i++)
                chk($sformatf("stage_ena%0d", i), int'(stage_ena[i]),
                    int'(!hold && m_pipe[i-1] >= 0));
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("stage_vld%0d", i), int'(stage_vld[i]), int'(m_pipe[i] >= 0));
                if (m_pipe[i] >= 0)
                    chk($sformatf("stage_op%0d", i), int'(stage_op[i]), m_pipe[i]);
            end
            chk("count", int'(count), m_count);
            chk("empty", int'(empty), int'(m_count == 0));
            chk("full", int'(full), int'(m_count == CAP));
            chk("del_ack", int'(del_ack), int'(m_ack));
            chk("del_tag", int'(del_tag), m_tag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int t0;
    int ack_cyc;
    int n_ins, n_del, n_alt_bad, n_acks;
    int last_ev;

    initial begin
        // reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_vld", int'(stage_vld), 0);
        chk("rst_ack", int'(del_ack), 0);
        chk("rst_tag", int'(del_tag), 0);
        chk("rst_empty", int'(empty), 1);
        step();

        // three back-to-back inserts
        ins_valid = 1'b1;
        ins_tag = 12'h123; @(negedge clk); chk("ins1_ena", int'(stage_ena[0]), 1); step();
        ins_tag = 12'h045; @(negedge clk); chk("ins2_ena", int'(stage_ena[0]), 1); step();
        ins_tag = 12'h800; @(negedge clk); chk("ins3_ena", int'(stage_ena[0]), 1); step();
        ins_valid = 1'b0;
        @(negedge clk); chk("walk_vld_a", int'(stage_vld), 3'b111); step();
        @(negedge clk); chk("walk_vld_b", int'(stage_vld), 3'b110); step();
        @(negedge clk); chk("walk_vld_c", int'(stage_vld), 3'b100); step();
        @(negedge clk);
        chk("ins_count", int'(count), 3);
        chk("ins_drained", int'(stage_vld), 0);

        // delete on an empty pipeline issues immediately
        min_tag_in = 12'h045;
        del_req = 1'b1;
        #1;
        chk("del_issue_now", int'(stage_ena[0]), 1);
        chk("del_issue_tag", int'(issue_tag), 12'h045);
        step();
        del_req = 1'b0;
        @(negedge clk);
        chk("del_ack_next", int'(del_ack), 1);
        chk("del_tag_val", int'(del_tag), 12'h045);
        chk("del_count", int'(count), 2);
        step();

        // insert at t, delete requested at t+1 must drain first
        min_tag_in = 12'h0a7;
        ins_valid = 1'b1; ins_tag = 12'h3c3;
        t0 = cyc;
        step();
        ins_valid = 1'b0; del_req = 1'b1;
        ack_cyc = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cyc == t0 + 2) chk("drain_ready", int'(ins_ready), 0);
            if (cyc == t0 + NS + 1) chk("drain_issue", int'(stage_ena[0]), 1);
            if (del_ack) begin
                ack_cyc = cyc;
                del_req = 1'b0;
                break;
            end
            step();
        end
        chk("drain_ack_cycle", ack_cyc - t0, NS + 2);
        chk("drain_tag", int'(del_tag), 12'h0a7);
        chk("drain_count", int'(count), 2);
        del_req = 1'b0;
        step();

        // both requesters held: issues alternate, neither starves
        ins_valid = 1'b1; del_req = 1'b1; min_tag_in = 12'h011;
        n_ins = 0; n_del = 0; n_alt_bad = 0; last_ev = -1;
        for (int k = 0; k < 30; k++) begin
            ins_tag = TAG_W'(12'h200 + k);
            @(negedge clk);
            if (del_ack) begin
                n_del++;
                if (last_ev == 1) n_alt_bad++;
                last_ev = 1;
            end
            if (ins_valid && ins_ready) begin
                n_ins++;
                if (last_ev == 0) n_alt_bad++;
                last_ev = 0;
            end
            step();
        end
        ins_valid = 1'b0; del_req = 1'b0;
        chk("fair_ins_min", int'(n_ins >= 5), 1);
        chk("fair_del_min", int'(n_del >= 4), 1);
        chk("fair_alternate", n_alt_bad, 0);
        for (int k = 0; k < 8; k++) step();

        // fill to capacity
        rst = 1'b1; step(); rst = 1'b0;
        ins_valid = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            ins_tag = TAG_W'(k);
            step();
        end
        @(negedge clk);
        chk("full_count", int'(count), CAP);
        chk("full_flag", int'(full), 1);
        chk("full_ready", int'(ins_ready), 0);
        step();
        @(negedge clk);
        chk("full_hold_count", int'(count), CAP);
        ins_valid = 1'b0;
        step();

        // delete on an empty tree is ignored
        rst = 1'b1; step(); rst = 1'b0;
        del_req = 1'b1;
        n_acks = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (del_ack || stage_ena[0]) n_acks++;
            step();
        end
        chk("empty_del_ignored", n_acks, 0);
        del_req = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;

        // hold in the middle of a drain, then reset mid-flight
        ins_valid = 1'b1; ins_tag = 12'h0f0; step();
        ins_tag = 12'h0f1; step();
        ins_valid = 1'b0; del_req = 1'b1; min_tag_in = 12'h0f0; step();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_vld", int'(stage_vld), 3'b110);
            chk("hold_count", int'(count), 2);
            chk("hold_ena", int'(stage_ena), 0);
            chk("hold_ready", int'(ins_ready), 0);
            step();
        end
        hold = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; del_req = 1'b0;
        @(negedge clk);
        chk("rst2_vld", int'(stage_vld), 0);
        chk("rst2_count", int'(count), 0);
        chk("rst2_ack", int'(del_ack), 0);
        chk("rst2_tag", int'(del_tag), 0);
        chk("rst2_run_ready", int'(ins_ready), 1);
        chk("rst2_ena", int'(stage_ena), 0);
        n_acks = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            if (del_ack) n_acks++;
        end
        chk("rst2_no_ack", n_acks, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_sort_pipe_ctrl.md
# tag_sort_pipe_ctrl

- Sequencing controller for the multibit-tree tag sorter.
- Arbitrates between an insert requester and a delete-min requester, and issues at most one operation per cycle into stage 1.
- Generates the per-stage register enables, and tracks per-stage valid/op and tree occupancy.
- Enforces the delete-after-drain hazard rule.

## Interface
Parameters:
- TAG_W, 12, tag width (3 × 4-bit tree levels)
- NUM_STAGES, 3, pipeline stage registers sequenced
- CAP, 64, maximum stored tags
- CNT_W, 7, occupancy counter width (≥ clog2(CAP+1))

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hold  in  1  downstream freeze: no issue, all stage_ena low
- ins_valid  in  1  insert request
- ins_tag  in  TAG_W  tag to insert
- ins_ready  out  1  insert accepted this cycle when ins_valid & ins_ready
- del_req  in  1  level delete-min request, held until del_ack
- del_ack  out  1  one-cycle pulse, delete completed
- del_tag  out  TAG_W  removed minimum tag, valid with del_ack
- min_tag_in  in  TAG_W  tree minimum, meaningful only when pipeline empty
- issue_tag  out  TAG_W  tag driven into stage 1 data input
- stage_ena  out  NUM_STAGES  load enable per stage register
- stage_vld  out  NUM_STAGES  stage i holds a live op
- stage_op  out  NUM_STAGES  0 = insert, 1 = delete
- count  out  CNT_W  committed occupancy
- empty, full  out  1  count==0, count==CAP

## Operation
- Pipeline empty means stage_vld == 0.
- FSM has two states:
  - RUN:
    - Grant follows the `pri` bit when both ins_valid and eligible del_req are present.
    - A delete is eligible if del_req & ~empty.
    - An insert is eligible if ins_valid & ~full & ~hold.
    - Granted delete with pipeline empty: issue the delete this cycle.
    - Granted delete with pipeline busy: go to DRAIN and issue nothing this cycle.
  - DRAIN:
    - No inserts are issued; ins_ready = 0.
    - When the pipeline is empty & ~hold: issue the delete and return to RUN.
- `pri` toggles after every issue so the other requester is favoured next.
- Insert issue:
  - issue_tag = ins_tag, stage_op entering = 0, count += 1.
  - Back-to-back inserts are allowed, including directly behind a delete.
- Delete issue:
  - issue_tag = min_tag_in, stage_op entering = 1, count −= 1.
  - del_tag <= min_tag_in; del_ack pulses the next cycle.
- Only one issue per cycle, so count never increments and decrements together. It cannot wrap because full and empty gate issue.
- stage_ena is combinational:
  - stage_ena[0] = issue.
  - stage_ena[i] = ~hold & stage_vld[i−1].
- stage_vld/op shift on ~hold. The valid bit of a stage with no incoming op clears.
- hold:
  - All shifting and issue freeze.
  - FSM state, count and pri are held.
  - ins_ready = 0.
  - A pending del_ack still pulses.
- del_req while empty is ignored: no ack, FSM stays in RUN.
- Reset (applies mid-operation as well, aborting any drain):
  - stage_vld = 0, stage_op = 0, count = 0, del_ack = 0, del_tag = 0.
  - FSM = RUN, pri = insert-preferred.

## Timing
- Insert accepted at cycle t:
  - stage_vld[0] is high at t+1.
  - The op occupies stage NUM_STAGES−1 at t+NUM_STAGES and leaves the pipeline after that.
- Delete on an empty pipeline: issue at t, del_ack/del_tag at t+1.
- Delete behind k live stages:
  - Enters DRAIN at t.
  - Issue happens at the first cycle with the pipeline empty & ~hold, ≤ t+NUM_STAGES absent hold.
  - del_ack follows one cycle after issue.
- ins_ready is combinational from FSM state, full, hold and the arbitration result.
- No combinational path from del_req to del_ack.

## Structure
- Shared package `tag_sort_pkg`:
  - TAG_W, NUM_STAGES.
  - Op encodings OP_INS / OP_DEL.
  - FSM state encoding ST_RUN / ST_DRAIN.
- One sub-module, `tag_sort_vld_pipe`: the NUM_STAGES valid/op shift register with hold, producing stage_vld, stage_op and stage_ena[NUM_STAGES−1:1].
- Arbiter, FSM and counter stay in the top.

## Test plan
- Reset then insert tags 0x123, 0x045, 0x800 on consecutive cycles:
  - stage_ena[0] high for 3 cycles.
  - stage_vld walks through all stages.
  - count = 3.
- Empty pipeline, count=3, min_tag_in=0x045, del_req:
  - Issue in the same cycle.
  - del_ack one cycle later with del_tag=0x045.
  - count=2.
- Insert at t, del_req at t+1:
  - FSM enters DRAIN and ins_ready=0.
  - Delete issues at t+NUM_STAGES+1.
  - del_ack at t+NUM_STAGES+2.
- ins_valid and del_req both held continuously with count in range:
  - Issues alternate insert/delete, each delete after a drain.
  - Neither requester starves.
- count=CAP with ins_valid: ins_ready=0. With count=0 and del_req: no ack for 20 cycles.
- hold asserted for 4 cycles mid-drain, then rst asserted mid-flight:
  - During hold, stage_vld and count are frozen.
  - After rst, all outputs are at their reset values and the FSM is in RUN.
